fx2_bus_arbiter: RTL



---
 rtl/fx2_arb_pkg.sv | 18 +
 rtl/fx2_bus_arbiter_if.sv | 27 ++
 rtl/fx2_arb_timer.sv | 37 +++
 rtl/fx2_bus_arbiter.sv | 111 +++++++++++
 4 files changed

// File: rtl/fx2_arb_pkg.sv
// rtl/fx2_arb_pkg.sv - state encoding and default timing constants for the FX2 bus arbiter
package fx2_arb_pkg;

  localparam int ARB_STATE_W     = 3;
  localparam int TIMER_W         = 16;
  localparam int TURN_CYCLES_DEF = 4;
  localparam int TX_HOLD_DEF     = 4096;

  typedef enum logic [ARB_STATE_W-1:0] {
    ARB_TURN_RX  = 3'd0,
    ARB_RX       = 3'd1,
    ARB_RX_DRAIN = 3'd2,
    ARB_TURN_TX  = 3'd3,
    ARB_TX       = 3'd4,
    ARB_TX_DRAIN = 3'd5
  } arb_state_e;

endpackage

// File: rtl/fx2_bus_arbiter_if.sv
// rtl/fx2_bus_arbiter_if.sv - request/grant bundle between the arbiter and the EP2/EP6 engines
interface fx2_bus_arbiter_if;
  import fx2_arb_pkg::*;

  logic                   upload_req;
  logic                   tx_fifo_empty;
  logic                   tx_busy;
  logic                   rx_busy;
  logic                   fx2_flagb;
  logic                   rx_grant;
  logic                   tx_grant;
  logic                   bus_oe;
  logic                   mux_sel;
  logic                   cmd_waiting;
  logic [ARB_STATE_W-1:0] arb_state;

  modport master (
    input  upload_req, tx_fifo_empty, tx_busy, rx_busy, fx2_flagb,
    output rx_grant, tx_grant, bus_oe, mux_sel, cmd_waiting, arb_state
  );

  modport slave (
    output upload_req, tx_fifo_empty, tx_busy, rx_busy, fx2_flagb,
    input  rx_grant, tx_grant, bus_oe, mux_sel, cmd_waiting, arb_state
  );

endinterface

// File: rtl/fx2_arb_timer.sv
// rtl/fx2_arb_timer.sv - 16-bit loadable down counter that saturates at zero
module fx2_arb_timer
  import fx2_arb_pkg::*;
#(
  parameter logic [TIMER_W-1:0] RESET_VAL = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               dec,
  output logic               zero
);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= RESET_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/fx2_bus_arbiter.sv
// rtl/fx2_bus_arbiter.sv - registered owner sequencing of the FX2 Slave-FIFO bus (EP2 read / EP6 write)
module fx2_bus_arbiter
  import fx2_arb_pkg::*;
#(
  parameter int TURN_CYCLES = TURN_CYCLES_DEF,
  parameter int TX_HOLD     = TX_HOLD_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  fx2_bus_arbiter_if.master  bus
);

  localparam logic [ARB_STATE_W-1:0] ST_TURN_RX  = ARB_TURN_RX;
  localparam logic [ARB_STATE_W-1:0] ST_RX       = ARB_RX;
  localparam logic [ARB_STATE_W-1:0] ST_RX_DRAIN = ARB_RX_DRAIN;
  localparam logic [ARB_STATE_W-1:0] ST_TURN_TX  = ARB_TURN_TX;
  localparam logic [ARB_STATE_W-1:0] ST_TX       = ARB_TX;
  localparam logic [ARB_STATE_W-1:0] ST_TX_DRAIN = ARB_TX_DRAIN;

  // The turn timer is reloaded one short so a turnaround state lasts exactly TURN_CYCLES clocks.
  localparam logic [TIMER_W-1:0] TURN_RST  = TIMER_W'(TURN_CYCLES);
  localparam logic [TIMER_W-1:0] TURN_LOAD = TIMER_W'(TURN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] HOLD_LOAD = TIMER_W'(TX_HOLD);

  logic [ARB_STATE_W-1:0] state_q, state_d;
  logic rx_grant_q, rx_grant_d;
  logic tx_grant_q, tx_grant_d;
  logic bus_oe_q, bus_oe_d;
  logic mux_sel_q, mux_sel_d;
  logic cmd_waiting_q, cmd_waiting_d;

  logic turn_active, turn_zero;
  logic hold_dec, hold_load, hold_zero;

  assign turn_active = (state_q == ST_TURN_RX) || (state_q == ST_TURN_TX);
  assign hold_load   = (state_q != ST_TX);
  assign hold_dec    = (state_q == ST_TX) && cmd_waiting_q;

  fx2_arb_timer #(.RESET_VAL(TURN_RST)) u_turn_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (!turn_active),
    .load_val (TURN_LOAD),
    .dec      (turn_active),
    .zero     (turn_zero)
  );

  fx2_arb_timer #(.RESET_VAL(HOLD_LOAD)) u_hold_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (hold_load),
    .load_val (HOLD_LOAD),
    .dec      (hold_dec),
    .zero     (hold_zero)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_TURN_RX:  if (turn_zero) state_d = ST_RX;
      ST_RX:       if (bus.upload_req && !bus.tx_fifo_empty) state_d = ST_RX_DRAIN;
      ST_RX_DRAIN: if (!bus.rx_busy) state_d = ST_TURN_TX;
      ST_TURN_TX:  if (turn_zero) state_d = ST_TX;
      ST_TX: begin
        if ((!bus.upload_req && bus.tx_fifo_empty) || hold_zero) state_d = ST_TX_DRAIN;
      end
      ST_TX_DRAIN: if (!bus.tx_busy) state_d = ST_TURN_RX;
      default:     state_d = ST_TURN_RX;
    endcase
  end

  // Outputs are decoded from the next state so they land on the same edge as the state register.
  always_comb begin
    rx_grant_d    = (state_d == ST_RX);
    tx_grant_d    = (state_d == ST_TX);
    bus_oe_d      = (state_d == ST_TX) || (state_d == ST_TX_DRAIN);
    mux_sel_d     = (state_d == ST_TURN_TX) || (state_d == ST_TX) || (state_d == ST_TX_DRAIN);
    cmd_waiting_d = cmd_waiting_q;
    if (state_d == ST_RX) begin
      cmd_waiting_d = 1'b0;
    end else if ((state_q == ST_TX) && bus.fx2_flagb) begin
      cmd_waiting_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_TURN_RX;
      rx_grant_q    <= 1'b0;
      tx_grant_q    <= 1'b0;
      bus_oe_q      <= 1'b0;
      mux_sel_q     <= 1'b0;
      cmd_waiting_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rx_grant_q    <= rx_grant_d;
      tx_grant_q    <= tx_grant_d;
      bus_oe_q      <= bus_oe_d;
      mux_sel_q     <= mux_sel_d;
      cmd_waiting_q <= cmd_waiting_d;
    end
  end

  assign bus.rx_grant    = rx_grant_q;
  assign bus.tx_grant    = tx_grant_q;
  assign bus.bus_oe      = bus_oe_q;
  assign bus.mux_sel     = mux_sel_q;
  assign bus.cmd_waiting = cmd_waiting_q;
  assign bus.arb_state   = state_q;

endmodule
